wr_frame_sched: RTL

- Upstream feeder for the DDR AXI write-channel controller in the video capture path.
- Buffers packed 128-bit pixel words from the capture/packing stage in an internal FWFT FIFO.
- Once a full burst is buffered, issues one write command (wr_en/wr_addr/wr_id/wr_len), then streams data beats whenever the downstream wr_ready is high.
- Walks linear addresses through ping-pong frame buffers in DDR, re-based on each frame-start pulse.

---
 rtl/ddr_hdmi_pkg.sv | 24 ++
 rtl/wr_sync_fifo_fwft.sv | 69 ++++++
 rtl/wr_frame_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ddr_hdmi_pkg.sv
// Shared types and constants for the DDR write-path frame scheduler.
//   wr_state_e    : scheduler FSM states (IDLE/CMD/DATA/NEXT)
//   BEAT_W_DEF    : beat width for the default 16-bit DQ (MEM_DQ_WIDTH*8)
//   ADDR_PER_BEAT : controller address units consumed by one beat
package ddr_hdmi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        NEXT = 2'd3
    } wr_state_e;

    localparam int unsigned DQ_BITS_PER_BEAT = 8;
    localparam int unsigned MEM_DQ_WIDTH_DEF = 16;
    localparam int unsigned BEAT_W_DEF       = MEM_DQ_WIDTH_DEF * DQ_BITS_PER_BEAT;
    localparam int unsigned ADDR_PER_BEAT    = 8;

    // Beat width for a given DQ width.
    function automatic int unsigned beat_width(input int unsigned dq_w);
        return dq_w * DQ_BITS_PER_BEAT;
    endfunction

endpackage

// File: rtl/wr_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
//   push_i/data_i : write side (ignored while full)
//   pop_i         : consume head word (ignored while empty)
//   data_o        : head word, valid in the same cycle it is at the head
//   cnt_o         : words stored, full_o/empty_o derived from it
// DEPTH must be a power of two so pointers wrap naturally.
module wr_sync_fifo_fwft #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign cnt_o   = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Upstream logic guarantees a full burst is buffered before popping.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o))
        else $error("wr_sync_fifo_fwft: pop while empty");
`endif

endmodule

// File: rtl/wr_frame_sched.sv
// Frame write scheduler: buffers pixel words, issues one write command per
// buffered burst, streams beats on wr_ready and walks ping-pong frame buffers.
//   frame_start/in_valid/in_data/in_ready : capture-side input stream
//   wr_en/wr_addr/wr_id/wr_len            : write command to the DDR controller
//   wr_ready/wr_data/wr_cmd_done          : data beats and last-beat handshake
//   frame_idx                             : frame buffer currently written
//   ovf_err/seq_err                       : sticky error flags
// Build option: define WR_FRAME_TRIPLE_BUF_EN for three frame buffers
// (default is two, frame_idx[1] stays 0).
module wr_frame_sched
    import ddr_hdmi_pkg::*;
#(
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned MEM_DQ_WIDTH    = 16,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned FRAME_BASE      = 0,
    parameter int unsigned FRAME_SIZE      = 'h10_0000,
    parameter int unsigned AXI_ID          = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic                         in_valid,
    input  logic [MEM_DQ_WIDTH*8-1:0]    in_data,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic [CTRL_ADDR_WIDTH-1:0]   wr_addr,
    output logic [3:0]                   wr_id,
    output logic [3:0]                   wr_len,
    input  logic                         wr_ready,
    output logic [MEM_DQ_WIDTH*8-1:0]    wr_data,
    input  logic                         wr_cmd_done,
    output logic [1:0]                   frame_idx,
    output logic                         ovf_err,
    output logic                         seq_err
);

    localparam int unsigned AW     = CTRL_ADDR_WIDTH;
    localparam int unsigned BEAT_W = beat_width(MEM_DQ_WIDTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned STEP   = BURST_LEN * ADDR_PER_BEAT;

    wr_state_e         state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [BCNT_W-1:0] beat_q, beat_d;
    logic              ovf_q, ovf_d;
    logic              seq_q, seq_d;

    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              last_beat;
    logic [1:0]        next_idx;
    logic [AW-1:0]     offset;

    // Start address of frame buffer idx.
    function automatic logic [AW-1:0] base_of(input logic [1:0] idx);
        return AW'(FRAME_BASE) + AW'(idx) * AW'(FRAME_SIZE);
    endfunction

`ifdef WR_FRAME_TRIPLE_BUF_EN
    assign next_idx = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
`else
    assign next_idx = {1'b0, ~idx_q[0]};
`endif

    assign in_ready  = ~fifo_full;
    assign push      = in_valid & in_ready;
    assign pop       = (state_q == DATA) & wr_ready;
    assign last_beat = (beat_q == BCNT_W'(BURST_LEN - 1));

    assign wr_en     = wr_en_q;
    assign wr_addr   = addr_q;
    assign wr_id     = 4'(AXI_ID);
    assign wr_len    = 4'(BURST_LEN - 1);
    assign frame_idx = idx_q;
    assign ovf_err   = ovf_q;
    assign seq_err   = seq_q;

    wr_sync_fifo_fwft #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (in_data),
        .pop_i   (pop),
        .data_o  (wr_data),
        .cnt_o   (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state and register-input logic.
    always_comb begin
        state_d = state_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pend_d  = pend_q | frame_start;
        beat_d  = beat_q;
        ovf_d   = ovf_q | (in_valid & ~in_ready);
        seq_d   = seq_q;
        offset  = addr_q - base_of(idx_q) + AW'(STEP);

        case (state_q)
            IDLE: begin
                // Frame switch takes priority so a burst never straddles frames.
                if (pend_q) begin
                    addr_d = base_of(next_idx);
                    idx_d  = next_idx;
                    pend_d = frame_start;
                end else if (fifo_cnt >= CNT_W'(BURST_LEN)) begin
                    state_d = CMD;
                    wr_en_d = 1'b1;
                end
            end
            CMD: begin
                state_d = DATA;
            end
            DATA: begin
                if (wr_cmd_done && !last_beat) seq_d = 1'b1;
                if (wr_ready) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = NEXT;
                        if (!wr_cmd_done) seq_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BCNT_W'(1);
                    end
                end
            end
            NEXT: begin
                addr_d  = (offset >= AW'(FRAME_SIZE)) ? base_of(idx_q) : addr_q + AW'(STEP);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= AW'(FRAME_BASE);
            idx_q   <= 2'd0;
            pend_q  <= 1'b0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
            seq_q   <= seq_d;
        end
    end

endmodule
